// File: rtl/branch_redirect_if.sv
// Execute-lane resolution inputs and frontend redirect handshake for branch_redirect_ctrl.
// slave is the controller side; master is the pipeline/frontend side.
interface branch_redirect_if #(
  parameter int unsigned CNT_W = 32
);
  logic [1:0]       ex_valid;
  logic [1:0]       ex_is_branch;
  logic [31:0]      ex_pc0;
  logic [31:0]      ex_pc1;
  logic [1:0]       ex_taken;
  logic [31:0]      ex_target0;
  logic [31:0]      ex_target1;
  logic [1:0]       pred_taken;
  logic [31:0]      pred_target0;
  logic [31:0]      pred_target1;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             redirect_ready;
  logic             flush;
  logic             stall;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispred_cnt;

  modport slave (
    input  ex_valid, ex_is_branch, ex_pc0, ex_pc1, ex_taken, ex_target0, ex_target1,
    input  pred_taken, pred_target0, pred_target1, redirect_ready,
    output redirect_valid, redirect_pc, flush, stall, branch_cnt, mispred_cnt
  );

  modport master (
    output ex_valid, ex_is_branch, ex_pc0, ex_pc1, ex_taken, ex_target0, ex_target1,
    output pred_taken, pred_target0, pred_target1, redirect_ready,
    input  redirect_valid, redirect_pc, flush, stall, branch_cnt, mispred_cnt
  );
endinterface

// File: rtl/branch_redirect_ctrl.sv
// Picks the oldest mispredicting branch of two in-order execute lanes, issues a frontend
// redirect with a one-cycle flush, and ignores wrong-path lanes until the pipeline drains.
module branch_redirect_ctrl #(
  parameter int unsigned KILL_CYCLES = 2,
  parameter int unsigned CNT_W       = 32
) (
  input logic              clk,
  input logic              rst,
  branch_redirect_if.slave bus
);

  localparam logic [1:0] StIdle     = 2'd0;
  localparam logic [1:0] StRedirect = 2'd1;
  localparam logic [1:0] StKill     = 2'd2;
  localparam int unsigned CntW1     = CNT_W + 1;

  logic [1:0]       state_q, state_d;
  logic [3:0]       kill_q, kill_d;
  logic [31:0]      pc_q, pc_d;
  logic             flush_q, flush_d;
  logic [CNT_W-1:0] br_q, br_d;
  logic [CNT_W-1:0] mis_q, mis_d;

  logic        cand0, cand1, mis0, mis1;
  logic [31:0] fix_pc0, fix_pc1;
  logic [1:0]  br_inc;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [1:0] inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + CntW1'(inc);
    return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

  assign cand0 = bus.ex_valid[0] & bus.ex_is_branch[0];
  assign cand1 = bus.ex_valid[1] & bus.ex_is_branch[1];

  assign mis0 = cand0 & ((bus.ex_taken[0] != bus.pred_taken[0]) |
                         (bus.ex_taken[0] & (bus.ex_target0 != bus.pred_target0)));
  assign mis1 = cand1 & ((bus.ex_taken[1] != bus.pred_taken[1]) |
                         (bus.ex_taken[1] & (bus.ex_target1 != bus.pred_target1)));

  assign fix_pc0 = bus.ex_taken[0] ? bus.ex_target0 : bus.ex_pc0 + 32'd4;
  assign fix_pc1 = bus.ex_taken[1] ? bus.ex_target1 : bus.ex_pc1 + 32'd4;

  // An older mispredict squashes lane 1, so it is not counted either.
  assign br_inc = mis0 ? 2'd1 : ({1'b0, cand0} + {1'b0, cand1});

  always_comb begin
    state_d = state_q;
    kill_d  = kill_q;
    pc_d    = pc_q;
    flush_d = 1'b0;
    br_d    = br_q;
    mis_d   = mis_q;
    unique case (state_q)
      StIdle: begin
        br_d = sat_add(br_q, br_inc);
        if (mis0 | mis1) begin
          state_d = StRedirect;
          pc_d    = mis0 ? fix_pc0 : fix_pc1;
          flush_d = 1'b1;
          mis_d   = sat_add(mis_q, 2'd1);
        end
      end
      StRedirect: begin
        if (bus.redirect_ready) begin
          if (KILL_CYCLES == 0) begin
            state_d = StIdle;
          end else begin
            state_d = StKill;
            kill_d  = 4'(KILL_CYCLES);
          end
        end
      end
      StKill: begin
        kill_d = kill_q - 4'd1;
        if (kill_q == 4'd1) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      kill_q  <= 4'd0;
      pc_q    <= 32'd0;
      flush_q <= 1'b0;
      br_q    <= '0;
      mis_q   <= '0;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
      pc_q    <= pc_d;
      flush_q <= flush_d;
      br_q    <= br_d;
      mis_q   <= mis_d;
    end
  end

  assign bus.redirect_valid = (state_q == StRedirect);
  assign bus.redirect_pc    = pc_q;
  assign bus.flush          = flush_q;
  assign bus.stall          = (state_q != StIdle);
  assign bus.branch_cnt     = br_q;
  assign bus.mispred_cnt    = mis_q;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed-vector bench for branch_redirect_ctrl; a second 2-bit-counter instance
// shares the stimulus to exercise counter saturation.
module tb_branch_redirect_ctrl;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  branch_redirect_if #(.CNT_W(32)) bus_a ();
  branch_redirect_if #(.CNT_W(2))  bus_b ();

  branch_redirect_ctrl #(.KILL_CYCLES(2), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  branch_redirect_ctrl #(.KILL_CYCLES(2), .CNT_W(2)) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  assign bus_b.ex_valid       = bus_a.ex_valid;
  assign bus_b.ex_is_branch   = bus_a.ex_is_branch;
  assign bus_b.ex_pc0         = bus_a.ex_pc0;
  assign bus_b.ex_pc1         = bus_a.ex_pc1;
  assign bus_b.ex_taken       = bus_a.ex_taken;
  assign bus_b.ex_target0     = bus_a.ex_target0;
  assign bus_b.ex_target1     = bus_a.ex_target1;
  assign bus_b.pred_taken     = bus_a.pred_taken;
  assign bus_b.pred_target0   = bus_a.pred_target0;
  assign bus_b.pred_target1   = bus_a.pred_target1;
  assign bus_b.redirect_ready = bus_a.redirect_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic clear_lanes();
    bus_a.ex_valid     = 2'b00;
    bus_a.ex_is_branch = 2'b00;
    bus_a.ex_pc0       = '0;
    bus_a.ex_pc1       = '0;
    bus_a.ex_taken     = 2'b00;
    bus_a.ex_target0   = '0;
    bus_a.ex_target1   = '0;
    bus_a.pred_taken   = 2'b00;
    bus_a.pred_target0 = '0;
    bus_a.pred_target1 = '0;
  endtask

  task automatic set_lane(input int lane, input logic [31:0] pc, input logic tk,
                          input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
    bus_a.ex_valid[lane]     = 1'b1;
    bus_a.ex_is_branch[lane] = 1'b1;
    bus_a.ex_taken[lane]     = tk;
    bus_a.pred_taken[lane]   = ptk;
    if (lane == 0) begin
      bus_a.ex_pc0       = pc;
      bus_a.ex_target0   = tgt;
      bus_a.pred_target0 = ptgt;
    end else begin
      bus_a.ex_pc1       = pc;
      bus_a.ex_target1   = tgt;
      bus_a.pred_target1 = ptgt;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic rv, input logic [31:0] pc,
                           input logic fl, input logic st, input logic [31:0] br,
                           input logic [31:0] mis);
    check_eq({tag, ".redirect_valid"}, 32'(bus_a.redirect_valid), 32'(rv));
    check_eq({tag, ".redirect_pc"}, bus_a.redirect_pc, pc);
    check_eq({tag, ".flush"}, 32'(bus_a.flush), 32'(fl));
    check_eq({tag, ".stall"}, 32'(bus_a.stall), 32'(st));
    check_eq({tag, ".branch_cnt"}, bus_a.branch_cnt, br);
    check_eq({tag, ".mispred_cnt"}, bus_a.mispred_cnt, mis);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    bus_a.redirect_ready = 1'b1;
    clear_lanes();
    #1;
    check_out("reset", 1'b0, 32'h0, 1'b0, 1'b0, 32'd0, 32'd0);
    tick();
    tick();
    rst = 1'b0;

    // Two correct branches per cycle: 32-bit counter climbs, 2-bit counter pins at 3.
    set_lane(0, 32'h100, 1'b0, 32'h0,   1'b0, 32'h0);
    set_lane(1, 32'h104, 1'b1, 32'h200, 1'b1, 32'h200);
    tick();
    check_out("corr1", 1'b0, 32'h0, 1'b0, 1'b0, 32'd2, 32'd0);
    check_eq("sat1", 32'(bus_b.branch_cnt), 32'd2);
    tick();
    check_eq("corr2.branch_cnt", bus_a.branch_cnt, 32'd4);
    check_eq("sat2", 32'(bus_b.branch_cnt), 32'd3);
    tick();
    check_eq("corr3.branch_cnt", bus_a.branch_cnt, 32'd6);
    check_eq("sat3", 32'(bus_b.branch_cnt), 32'd3);
    clear_lanes();

    // Lane 0 taken mispredict; then wrong-path mispredicts during KILL are ignored.
    set_lane(0, 32'h1C000010, 1'b1, 32'h1C000100, 1'b0, 32'h0);
    tick();
    check_out("beq", 1'b1, 32'h1C000100, 1'b1, 1'b1, 32'd7, 32'd1);
    clear_lanes();
    tick();
    check_out("beq.acc", 1'b0, 32'h1C000100, 1'b0, 1'b1, 32'd7, 32'd1);
    set_lane(0, 32'h600, 1'b1, 32'h700, 1'b0, 32'h0);
    tick();
    check_out("beq.kill", 1'b0, 32'h1C000100, 1'b0, 1'b1, 32'd7, 32'd1);
    tick();
    check_out("beq.idle", 1'b0, 32'h1C000100, 1'b0, 1'b0, 32'd7, 32'd1);
    clear_lanes();

    // Both lanes mispredict: lane 0 wins, lane 1 neither counted nor redirected.
    set_lane(0, 32'h80, 1'b0, 32'h0,   1'b1, 32'h500);
    set_lane(1, 32'h84, 1'b1, 32'h900, 1'b0, 32'h0);
    tick();
    check_out("both", 1'b1, 32'h84, 1'b1, 1'b1, 32'd8, 32'd2);
    clear_lanes();
    tick();
    tick();
    tick();
    check_eq("both.idle", 32'(bus_a.stall), 32'd0);

    // Lane 1 target mispredict behind a correct lane 0, frontend stalls 5 cycles.
    bus_a.redirect_ready = 1'b0;
    set_lane(0, 32'h40, 1'b0, 32'h0,    1'b0, 32'h0);
    set_lane(1, 32'h44, 1'b1, 32'h2000, 1'b1, 32'h3000);
    tick();
    check_out("bl", 1'b1, 32'h2000, 1'b1, 1'b1, 32'd10, 32'd3);
    clear_lanes();
    set_lane(0, 32'h1000, 1'b1, 32'h5554, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_out("hold", 1'b1, 32'h2000, 1'b0, 1'b1, 32'd10, 32'd3);
    end
    clear_lanes();
    bus_a.redirect_ready = 1'b1;
    tick();
    check_out("hold.acc", 1'b0, 32'h2000, 1'b0, 1'b1, 32'd10, 32'd3);
    tick();
    tick();
    check_eq("hold.idle", 32'(bus_a.stall), 32'd0);

    // Lane 1 alone, not-taken mispredict at the top of the address space wraps to 0.
    bus_a.redirect_ready = 1'b0;
    set_lane(1, 32'hFFFFFFFC, 1'b0, 32'h0, 1'b1, 32'h44);
    tick();
    check_out("wrap", 1'b1, 32'h0, 1'b1, 1'b1, 32'd11, 32'd4);
    clear_lanes();

    // Asynchronous reset while a redirect is still outstanding.
    #2;
    rst = 1'b1;
    #1;
    check_out("rstmid", 1'b0, 32'h0, 1'b0, 1'b0, 32'd0, 32'd0);
    tick();
    rst = 1'b0;
    bus_a.redirect_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("post_rst.redirect_valid", 32'(bus_a.redirect_valid), 32'd0);
      check_eq("post_rst.stall", 32'(bus_a.stall), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
